// File: rtl/serial_rx_align.sv
// Serial receive aligner: hunts for the idle comma bit-by-bit, confirms byte
// alignment over a run of consecutive aligned commas, then delivers one
// recovered byte every 8 bit clocks with a payload/comma flag.
module serial_rx_align #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       byte_stb,
  output logic       valid_out,
  output logic       active
);

  localparam int BCW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [BCW-1:0] LAST_BC = BCW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_COUNT,
    ST_ACTIVE
  } state_t;

  state_t         r_state;
  logic [7:0]     r_sr;
  logic [2:0]     r_bit_cnt;
  logic [BCW-1:0] r_bc_cnt;
  logic [7:0]     r_data_out;
  logic           r_byte_stb;
  logic           r_valid_out;

  state_t         w_state_next;
  logic [7:0]     w_sr_next;
  logic [2:0]     w_bit_cnt_next;
  logic [BCW-1:0] w_bc_cnt_next;
  logic           w_boundary;
  logic           w_is_comma;
  logic           w_load_byte;

  // The window including the bit arriving this cycle; all decisions use it.
  assign w_sr_next  = {r_sr[6:0], data_in};
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_is_comma = (w_sr_next == COMMA);

  // Next-state logic: hunt, confirm alignment, then deliver bytes forever.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt + 3'd1;
    w_bc_cnt_next  = r_bc_cnt;
    w_load_byte    = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_is_comma) begin
          // The comma just completed defines the byte boundary.
          w_bit_cnt_next = 3'd0;
          w_bc_cnt_next  = BCW'(1);
          w_state_next   = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            w_bc_cnt_next = r_bc_cnt + BCW'(1);
            if (r_bc_cnt == LAST_BC) begin
              w_state_next = ST_ACTIVE;
            end
          end else begin
            w_bc_cnt_next = '0;
            w_state_next  = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: begin
        // No loss-of-sync handling: only reset leaves this state.
        w_load_byte = w_boundary;
      end
      default: begin
        w_state_next  = ST_SEARCH;
        w_bc_cnt_next = '0;
      end
    endcase
  end

  // State, shift register and output registers; reset wins over everything.
  always_ff @(posedge clk_32f) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_sr        <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_bc_cnt    <= '0;
      r_data_out  <= 8'd0;
      r_byte_stb  <= 1'b0;
      r_valid_out <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sr       <= w_sr_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_bc_cnt   <= w_bc_cnt_next;
      r_byte_stb <= w_load_byte;
      if (w_load_byte) begin
        r_data_out  <= w_sr_next;
        r_valid_out <= !w_is_comma;
      end
    end
  end

  assign data_out  = r_data_out;
  assign byte_stb  = r_byte_stb;
  assign valid_out = r_valid_out;
  assign active    = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_serial_rx_align.sv
// Bench for serial_rx_align: directed scenarios plus random streams, checked
// by a bit-history reference model through a cycle queue and a byte queue.
module tb_serial_rx_align;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int LOCK_COUNT = 4;

  localparam int M_HUNT   = 0;
  localparam int M_COUNT  = 1;
  localparam int M_LOCKED = 2;

  typedef struct {
    bit rst;
    bit act;
    bit stb;
  } cyc_t;

  typedef struct {
    logic [7:0] d;
    bit         v;
  } byte_t;

  logic       clk_32f = 1'b0;
  logic       rst     = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       byte_stb;
  logic       valid_out;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;

  cyc_t  cyc_q[$];
  byte_t byte_q[$];

  // Reference model state: every bit since reset, the bit index where the
  // alignment comma ended, and how many aligned commas have been seen.
  bit bits[$];
  int m_mode   = M_HUNT;
  int m_anchor = 0;
  int m_commas = 0;

  serial_rx_align #(.COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk_32f  (clk_32f),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .byte_stb (byte_stb),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model of what the DUT shows after the edge that samples this bit.
  task automatic model_step(input bit r, input bit b, output cyc_t c);
    logic [7:0] w;
    int n;
    c.rst = r;
    c.stb = 1'b0;
    if (r) begin
      bits.delete();
      for (int k = 0; k < 8; k++) bits.push_back(1'b0);
      m_mode   = M_HUNT;
      m_commas = 0;
      m_anchor = 0;
    end else begin
      bits.push_back(b);
      n = bits.size();
      w = 8'd0;
      for (int k = 0; k < 8; k++) w = {w[6:0], bits[n-8+k]};
      if (m_mode == M_HUNT) begin
        if (w == COMMA) begin
          m_anchor = n;
          m_commas = 1;
          m_mode   = (m_commas >= LOCK_COUNT) ? M_LOCKED : M_COUNT;
        end
      end else if (((n - m_anchor) % 8) == 0) begin
        if (m_mode == M_COUNT) begin
          if (w == COMMA) begin
            m_commas++;
            if (m_commas >= LOCK_COUNT) m_mode = M_LOCKED;
          end else begin
            m_mode   = M_HUNT;
            m_commas = 0;
          end
        end else begin
          byte_t e;
          e.d = w;
          e.v = (w != COMMA);
          byte_q.push_back(e);
          c.stb = 1'b1;
        end
      end
    end
    c.act = (m_mode == M_LOCKED);
  endtask

  // One bit period: drive inputs away from the sampling edge and record the
  // expected outcome of the upcoming edge.
  task automatic drive(input bit r, input bit b);
    cyc_t c;
    @(negedge clk_32f);
    rst     = r;
    data_in = b;
    model_step(r, b, c);
    cyc_q.push_back(c);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive(1'b0, v[i]);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom_range(0, 1)));
  endtask

  // Monitor: compares each cycle's outputs, and pops a byte on every strobe.
  always @(posedge clk_32f) begin
    cyc_t  c;
    byte_t e;
    #1;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("active", int'(active), int'(c.act));
      chk("byte_stb", int'(byte_stb), int'(c.stb));
      if (c.rst) begin
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_valid_out", int'(valid_out), 0);
      end
      if (byte_stb === 1'b1) begin
        if (byte_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = byte_q.pop_front();
          chk("data_out", int'(data_out), int'(e.d));
          chk("valid_out", int'(valid_out), int'(e.v));
          $display("byte: data_out=%02h valid_out=%0b (expected %02h/%0b)",
                   data_out, valid_out, e.d, e.v);
        end
      end
    end
  end

  initial begin
    // 1: reset with random line, then idle zeros never lock.
    do_reset(3);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0);

    // 2: three junk bits, four commas, then one payload byte.
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    send_byte(8'h55);

    // 4: payload stream while locked.
    send_byte(8'hAA);
    send_byte(8'hCC);
    send_byte(8'hEE);
    send_byte(8'hDA);

    // 5: commas mixed with payload, plus a comma pattern straddling bytes.
    send_byte(COMMA);
    send_byte(8'hBB);
    send_byte(COMMA);
    send_byte(8'h0B);
    send_byte(8'hC0);

    // 6: reset mid-byte while active, then relock needs four fresh commas.
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    do_reset(1);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    send_byte(8'h12);
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    send_byte(8'h34);

    // 3: broken comma run returns to hunting.
    do_reset(2);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    send_byte(8'hAA);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    send_byte(8'h77);
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    send_byte(8'h99);

    // Random streams: optional reset, junk, a comma run, mixed payload.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) do_reset(int'($urandom_range(1, 2)));
      send_bits(int'($urandom_range(0, 20)));
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) send_byte(COMMA);
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) begin
        if ($urandom_range(0, 4) == 0) send_byte(COMMA);
        else send_byte(8'($urandom_range(0, 255)));
      end
    end

    // Drain so the monitor consumes the last expectations.
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0);
    @(posedge clk_32f);
    #3;
    @(posedge clk_32f);
    #3;
    chk("cycle_queue_drained", cyc_q.size(), 0);
    chk("byte_queue_drained", byte_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
